// File: rtl/fsm_counter_arbiter.sv
// Round-robin arbiter that drives the 4-bit command counter's `w` input with
// length-N bursts from two requesters. Define FSM_ARB_FIXED_PRIO_EN for fixed priority.
module fsm_counter_arbiter #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       cmd0,
  input  logic [1:0]       cmd1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [1:0]       w,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StGrant, StIssue, StDone} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             pick;

`ifdef FSM_ARB_FIXED_PRIO_EN
  // Requester 0 wins every tie.
  always_comb begin
    pick = ~req0;
  end
`else
  logic last_q, last_d;

  // On a tie the requester not granted last wins.
  always_comb begin
    pick = ~req0;
    if (req0 && req1) begin
      pick = ~last_q;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
`ifndef FSM_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          owner_d = pick;
          state_d = StGrant;
        end
      end
      StGrant: begin
        cmd_d   = owner_q ? cmd1 : cmd0;
        cnt_d   = owner_q ? len1 : len0;
        state_d = (cnt_d == '0) ? StDone : StIssue;
      end
      StIssue: begin
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
`ifndef FSM_ARB_FIXED_PRIO_EN
        last_d  = owner_q;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      cmd_q   <= 2'd0;
      cnt_q   <= '0;
`ifndef FSM_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
`ifndef FSM_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    gnt0  = (state_q == StGrant) && !owner_q;
    gnt1  = (state_q == StGrant) && owner_q;
    done0 = (state_q == StDone) && !owner_q;
    done1 = (state_q == StDone) && owner_q;
    w     = (state_q == StIssue) ? cmd_q : 2'd0;
    busy  = (state_q != StIdle);
  end

endmodule

// File: tb/tb_fsm_counter_arbiter.sv
// Scoreboard bench for fsm_counter_arbiter with a behavioural 4-bit command counter
// attached to `w`.
module tb_fsm_counter_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] cmd0 = 2'd0, cmd1 = 2'd0;
  logic [3:0] len0 = 4'd0, len1 = 4'd0;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [1:0] w;
  logic [3:0] ctr;
  bit         mon_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int owner;
    int cmd;
    int len;
  } burst_t;

  burst_t exp_q[$];

  fsm_counter_arbiter #(.LEN_W(4)) u_dut (
    .clock (clock),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .cmd0  (cmd0),
    .cmd1  (cmd1),
    .len0  (len0),
    .len1  (len1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .w     (w),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  // Counter attached to the arbiter: 0 hold, 1 +1, 2 +2, 3 -1.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctr <= 4'd0;
    end else begin
      case (w)
        2'd1:    ctr <= ctr + 4'd1;
        2'd2:    ctr <= ctr + 4'd2;
        2'd3:    ctr <= ctr - 4'd1;
        default: ctr <= ctr;
      endcase
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      check_val("gnt_excl", int'(gnt0 & gnt1), 0);
      check_val("done_excl", int'(done0 & done1), 0);
    end
  end

  task automatic expect_burst(input int owner, input int cmd, input int len);
    burst_t b;
    b.owner = owner;
    b.cmd   = cmd;
    b.len   = len;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    check_val("rst_outs", int'({gnt1, gnt0, done1, done0, busy, w}), 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Waits for the next grant and follows the burst through to its IDLE cycle.
  task automatic observe_burst(input bit drop);
    burst_t e;
    bit     seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock);
      seen = gnt0 | gnt1;
    end
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      check_val("gnt_timeout", 0, 1);
      return;
    end
    check_val("gnt_owner", int'({gnt1, gnt0}), 1 << e.owner);
    check_val("grant_w", int'(w), 0);
    check_val("grant_busy", int'(busy), 1);
    for (int i = 0; i < e.len; i++) begin
      @(negedge clock);
      if (drop && i == 0) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      check_val("issue_w", int'(w), e.cmd);
      check_val("issue_busy", int'(busy), 1);
      check_val("issue_pulses", int'({gnt1, gnt0, done1, done0}), 0);
    end
    @(negedge clock);
    check_val("done_owner", int'({done1, done0}), 1 << e.owner);
    check_val("done_w", int'(w), 0);
    check_val("done_busy", int'(busy), 1);
    @(negedge clock);
    check_val("idle_busy", int'(busy), 0);
  endtask

  initial begin
    do_reset();
    mon_en = 1'b1;

    // Single burst: +1 x3.
    req0 = 1'b1; cmd0 = 2'd1; len0 = 4'd3;
    expect_burst(0, 1, 3);
    observe_burst(1'b0);
    req0 = 1'b0;
    check_val("ctr_after_inc3", int'(ctr), 3);

    // Both requesting from reset, held through four bursts.
    do_reset();
    req0 = 1'b1; cmd0 = 2'd1; len0 = 4'd2;
    req1 = 1'b1; cmd1 = 2'd2; len1 = 4'd2;
`ifdef FSM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) expect_burst(0, 1, 2);
`else
    expect_burst(0, 1, 2);
    expect_burst(1, 2, 2);
    expect_burst(0, 1, 2);
    expect_burst(1, 2, 2);
`endif
    for (int i = 0; i < 4; i++) observe_burst(1'b0);
    req0 = 1'b0; req1 = 1'b0;
`ifdef FSM_ARB_FIXED_PRIO_EN
    check_val("ctr_after_rr", int'(ctr), 8);
`else
    check_val("ctr_after_rr", int'(ctr), 12);
`endif

    // Bring Q to 2, then subtract 5 with wrap to 13.
    do_reset();
    req0 = 1'b1; cmd0 = 2'd2; len0 = 4'd1;
    expect_burst(0, 2, 1);
    observe_burst(1'b0);
    req0 = 1'b0;
    check_val("ctr_at_2", int'(ctr), 2);
    req1 = 1'b1; cmd1 = 2'd3; len1 = 4'd5;
    expect_burst(1, 3, 5);
    observe_burst(1'b0);
    req1 = 1'b0;
    check_val("ctr_wrap_13", int'(ctr), 13);

    // Zero-length burst leaves the counter alone.
    req0 = 1'b1; cmd0 = 2'd2; len0 = 4'd0;
    expect_burst(0, 2, 0);
    observe_burst(1'b0);
    req0 = 1'b0;
    check_val("ctr_len0", int'(ctr), 13);

    // Request dropped right after grant; burst still completes.
    req0 = 1'b1; cmd0 = 2'd1; len0 = 4'd4;
    expect_burst(0, 1, 4);
    observe_burst(1'b1);
    check_val("ctr_drop", int'(ctr), 1);

    // Reset during the second ISSUE cycle of a len=6 burst.
    req0 = 1'b1; cmd0 = 2'd1; len0 = 4'd6;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge clock);
        seen = gnt0;
      end
      check_val("mid_gnt0", int'(seen), 1);
    end
    @(negedge clock);
    @(negedge clock);
    check_val("mid_issue_w", int'(w), 1);
    reset = 1'b0;
    #1;
    check_val("async_rst_outs", int'({gnt1, gnt0, done1, done0, busy, w}), 0);
    req0 = 1'b0;
    req1 = 1'b1; cmd1 = 2'd2; len1 = 4'd1;
    @(negedge clock);
    check_val("held_rst_outs", int'({gnt1, gnt0, done1, done0, busy, w}), 0);
    reset = 1'b1;
    expect_burst(1, 2, 1);
    observe_burst(1'b0);
    req1 = 1'b0;
    check_val("ctr_after_rst", int'(ctr), 2);

    check_val("sb_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
